// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states and transaction owner.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner selection between fetch and data requests.
// MEM_ARB_RR_EN selects round-robin; otherwise data has fixed priority over fetch.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   d_req,
    input  owner_t last_owner,
    output logic   valid,
    output owner_t winner
);

    assign valid = if_req | d_req;

`ifdef MEM_ARB_RR_EN
    // On a tie the port that did not own the previous grant wins.
    always_comb begin
        winner = OWN_D;
        if (if_req && d_req) begin
            winner = (last_owner == OWN_D) ? OWN_IF : OWN_D;
        end else if (if_req) begin
            winner = OWN_IF;
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        winner = d_req ? OWN_D : OWN_IF;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, one transaction at a time.
// Arbitration policy is chosen by MEM_ARB_RR_EN (round-robin) or its absence (data-first priority).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_t state;
    owner_t owner;
    owner_t last_owner;
    logic   pick_valid;
    owner_t pick_winner;
    logic   arb_go;
    logic   issue_acc;
    logic   resp_hit;

    arb_pick u_pick (
        .if_req     (if_req),
        .d_req      (d_req),
        .last_owner (last_owner),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    assign issue_acc = (state == S_ISSUE) && mem_ready;
    assign resp_hit  = (state == S_WAIT) && mem_rvalid;
    // A response cycle doubles as an arbitration slot so back-to-back traffic needs no idle cycle.
    assign arb_go    = pick_valid && ((state == S_IDLE) || resp_hit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            owner      <= OWN_IF;
            last_owner <= OWN_IF;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arb_go) begin
                        state <= S_ISSUE;
                        owner <= pick_winner;
                    end
                end
                S_ISSUE: begin
                    if (mem_ready) begin
                        state      <= S_WAIT;
                        last_owner <= owner;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        if (arb_go) begin
                            state <= S_ISSUE;
                            owner <= pick_winner;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (arb_go) begin
            mem_req <= 1'b1;
            if (pick_winner == OWN_D) begin
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else begin
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
            end
        end else if (issue_acc) begin
            mem_req <= 1'b0;
        end
    end

    assign if_gnt    = issue_acc && (owner == OWN_IF);
    assign d_gnt     = issue_acc && (owner == OWN_D);
    assign if_rvalid = resp_hit && (owner == OWN_IF);
    assign d_rvalid  = resp_hit && (owner == OWN_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: per-port expected queues, a behavioural memory and cycle stamps.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

`ifdef MEM_ARB_RR_EN
    localparam logic RR = 1'b1;
`else
    localparam logic RR = 1'b0;
`endif

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t if_q[$];
    txn_t d_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   if_gnt_cyc = 0, d_gnt_cyc = 0, if_rv_cyc = 0, d_rv_cyc = 0;
    int   k = 0;
    int   gnt_hist[$];

    // memory model controls
    logic        ovr_en = 1'b1, ovr_ready = 1'b0, ovr_rvalid = 1'b0;
    logic [31:0] ovr_rdata = '0;
    int          ready_delay = 0;
    logic        rand_mode = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] resp_data(input logic [31:0] a);
        if (a == 32'h4) return 32'h00A00513;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Behavioural memory: optional accept delay, response one or more cycles after accept.
    initial begin
        logic        busy, pend;
        int          wcnt, cur_delay, rv_wait;
        logic [31:0] pend_addr;
        busy = 0; pend = 0; wcnt = 0; cur_delay = 0; rv_wait = 0; pend_addr = '0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (ovr_en) begin
                mem_ready  = ovr_ready;
                mem_rvalid = ovr_rvalid;
                mem_rdata  = ovr_rdata;
                busy = 0; pend = 0; wcnt = 0;
            end else begin
                if (pend && rv_wait == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = resp_data(pend_addr);
                    pend       = 0;
                end else begin
                    if (pend) rv_wait--;
                    mem_rvalid = 1'b0;
                    mem_rdata  = $urandom;
                end
                if (mem_req) begin
                    if (!busy) begin
                        busy = 1;
                        wcnt = 0;
                        cur_delay = rand_mode ? int'($urandom_range(0, 3)) : ready_delay;
                    end
                    if (wcnt >= cur_delay) begin
                        mem_ready = 1'b1;
                        busy      = 0;
                        pend      = 1;
                        rv_wait   = rand_mode ? int'($urandom_range(0, 2)) : 0;
                        pend_addr = mem_addr;
                    end else begin
                        mem_ready = 1'b0;
                        wcnt++;
                    end
                end else begin
                    mem_ready = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    // Monitor: grants checked against queue front, responses pop the owning port's queue.
    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            #1;
            chk("rvalid_excl", 64'(if_rvalid & d_rvalid), 64'd0);
            chk("gnt_excl", 64'(if_gnt & d_gnt), 64'd0);
            if (!if_rvalid) chk("if_rdata_gate", 64'(if_rdata), 64'd0);
            if (!d_rvalid) chk("d_rdata_gate", 64'(d_rdata), 64'd0);
            if (if_gnt) begin
                if_gnt_cyc = cyc;
                if (if_q.size() == 0) chk("if_gnt_unexp", 64'(if_gnt), 64'd0);
                else begin
                    chk("if_gnt_addr", 64'(mem_addr), 64'(if_q[0].addr));
                    chk("if_gnt_we", 64'(mem_we), 64'd0);
                    chk("if_gnt_memreq", 64'(mem_req), 64'd1);
                end
            end
            if (d_gnt) begin
                d_gnt_cyc = cyc;
                if (d_q.size() == 0) chk("d_gnt_unexp", 64'(d_gnt), 64'd0);
                else begin
                    chk("d_gnt_addr", 64'(mem_addr), 64'(d_q[0].addr));
                    chk("d_gnt_we", 64'(mem_we), 64'(d_q[0].we));
                    if (d_q[0].we) chk("d_gnt_wdata", 64'(mem_wdata), 64'(d_q[0].wdata));
                end
            end
            if (if_rvalid) begin
                if_rv_cyc = cyc;
                if (if_q.size() == 0) chk("if_rvalid_unexp", 64'(if_rvalid), 64'd0);
                else begin
                    t = if_q.pop_front();
                    chk("if_rdata", 64'(if_rdata), 64'(resp_data(t.addr)));
                end
            end
            if (d_rvalid) begin
                d_rv_cyc = cyc;
                if (d_q.size() == 0) chk("d_rvalid_unexp", 64'(d_rvalid), 64'd0);
                else begin
                    t = d_q.pop_front();
                    chk("d_rdata", 64'(d_rdata), 64'(resp_data(t.addr)));
                end
            end
        end
    end

    task automatic do_fetch(input logic [31:0] a);
        txn_t t;
        logic got;
        t.we = 1'b0; t.addr = a; t.wdata = '0;
        if_q.push_back(t);
        if_req = 1'b1;
        if_addr = a;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            #1;
            got = if_gnt;
        end
        if (!got) chk("if_gnt_timeout", 64'(if_gnt), 64'd1);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        if_addr = $urandom;
    endtask

    task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd);
        txn_t t;
        logic got;
        t.we = we; t.addr = a; t.wdata = wd;
        d_q.push_back(t);
        d_req = 1'b1;
        d_we = we;
        d_addr = a;
        d_wdata = wd;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            #1;
            got = d_gnt;
        end
        if (!got) chk("d_gnt_timeout", 64'(d_gnt), 64'd1);
        @(posedge clk);
        #1;
        d_req = 1'b0;
        d_we = $urandom;
        d_addr = $urandom;
        d_wdata = $urandom;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (if_q.size() + d_q.size()) != 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("drain_left", 64'(if_q.size() + d_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;

        // reset held with random activity on every input
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if_req = 1'($urandom); if_addr = $urandom;
            d_req = 1'($urandom); d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
            ovr_ready = 1'($urandom); ovr_rvalid = 1'($urandom); ovr_rdata = $urandom;
            @(negedge clk);
            #1;
            chk("rst_mem_req", 64'(mem_req), 64'd0);
            chk("rst_mem_addr", 64'(mem_addr), 64'd0);
            chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
            chk("rst_ctrl", 64'({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_we}), 64'd0);
            chk("rst_rdata", {if_rdata, d_rdata}, 64'd0);
        end
        if_req = 0; d_req = 0; ovr_en = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("idle_after_rst", 64'(mem_req), 64'd0);
        end

        // single fetch latency
        @(posedge clk);
        #1;
        k = cyc;
        do_fetch(32'h4);
        drain();
        chk("fetch_gnt_lat", 64'(if_gnt_cyc - k), 64'd1);
        chk("fetch_rv_lat", 64'(if_rv_cyc - k), 64'd2);

        // a load leaves last_owner at data, then a simultaneous fetch and store
        do_data(1'b0, 32'h30, 32'h0);
        drain();
        fork
            do_fetch(32'h8);
            do_data(1'b1, 32'h10, 32'hDEADBEEF);
        join
        drain();
        chk("simul_fetch_first", 64'(if_gnt_cyc < d_gnt_cyc), 64'(RR));
        chk("simul_next_gnt", 64'(RR ? (d_gnt_cyc - if_rv_cyc) : (if_gnt_cyc - d_rv_cyc)), 64'd1);

        // memory stalls the request for five cycles
        ready_delay = 5;
        k = cyc;
        fork
            do_data(1'b1, 32'h40, 32'hCAFEF00D);
            begin
                @(negedge clk);
                for (int i = 1; i <= 5; i++) begin
                    @(negedge clk);
                    #1;
                    chk("stall_mem_req", 64'(mem_req), 64'd1);
                    chk("stall_addr", 64'(mem_addr), 64'h40);
                    chk("stall_wdata", 64'(mem_wdata), 64'hCAFEF00D);
                    chk("stall_no_gnt", 64'({d_gnt, if_gnt}), 64'd0);
                end
                @(negedge clk);
                #1;
                chk("stall_gnt_rise", 64'(d_gnt), 64'd1);
            end
        join
        drain();
        ready_delay = 0;
        chk("stall_gnt_cycle", 64'(d_gnt_cyc - k), 64'd6);

        // back-to-back stores: one transaction per two cycles
        gnt_hist.delete();
        for (int i = 0; i < 4; i++) begin
            do_data(1'b1, 32'h100 + 32'(4 * i), $urandom);
            gnt_hist.push_back(d_gnt_cyc);
        end
        drain();
        for (int i = 1; i < 4; i++) chk("b2b_spacing", 64'(gnt_hist[i] - gnt_hist[i-1]), 64'd2);

        // asynchronous reset while the request sits in S_ISSUE
        ovr_en = 1'b1; ovr_ready = 1'b0; ovr_rvalid = 1'b0; ovr_rdata = '0;
        @(posedge clk);
        #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h70; d_wdata = 32'h11223344;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("issue_mem_req", 64'(mem_req), 64'd1);
        d_req = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_async_mem_req", 64'(mem_req), 64'd0);
        chk("rst_async_addr", 64'(mem_addr), 64'd0);
        @(negedge clk);
        #2;
        rst = 1'b1;

        // reset in S_WAIT, then a late response after release
        ovr_ready = 1'b1;
        @(posedge clk);
        #1;
        do_fetch(32'h20);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_wait_mem_req", 64'(mem_req), 64'd0);
        chk("rst_wait_rvalid", 64'({if_rvalid, d_rvalid}), 64'd0);
        if_q.delete();
        @(negedge clk);
        #2;
        rst = 1'b1;
        ovr_ready = 1'b0; ovr_rvalid = 1'b1; ovr_rdata = 32'hAAAA5555;
        @(negedge clk);
        #1;
        chk("late_rvalid_ignored", 64'({if_rvalid, d_rvalid}), 64'd0);
        chk("late_mem_req", 64'(mem_req), 64'd0);

        // stray response while idle
        ovr_rdata = 32'h12345678;
        @(negedge clk);
        #1;
        chk("stray_rvalid", 64'({if_rvalid, d_rvalid}), 64'd0);
        chk("stray_rdata", {if_rdata, d_rdata}, 64'd0);
        ovr_rvalid = 1'b0;
        @(negedge clk);
        #1;
        chk("stray_still_idle", 64'(mem_req), 64'd0);
        ovr_en = 1'b0;

        // after reset the data port wins a tie in either policy
        @(posedge clk);
        #1;
        fork
            do_fetch(32'h50);
            do_data(1'b0, 32'h60, 32'h0);
        join
        drain();
        chk("tie_after_reset", 64'(d_gnt_cyc < if_gnt_cyc), 64'd1);

        // random concurrent traffic with random memory latency
        rand_mode = 1'b1;
        fork
            for (int i = 0; i < 8; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                do_fetch({$urandom_range(0, 255), 2'b00});
            end
            for (int j = 0; j < 8; j++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                do_data(1'($urandom), {$urandom_range(0, 255), 2'b00}, $urandom);
            end
        join
        drain();
        rand_mode = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-port memory between the CPU instruction-fetch path and the load/store data path. It accepts fetch and data requests, runs a 3-state FSM that issues one memory transaction at a time, and routes each response back to the requester that owns it. It sits between the CPU core and the unified memory once instruction and data memories merge into one array.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data word width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset: 0 resets, 1 runs
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  ADDR_WIDTH  fetch address
- if_gnt  out  1  one-cycle pulse: fetch accepted by memory
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DATA_WIDTH  fetch data
- d_req  in  1  data request, held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_gnt  out  1  one-cycle pulse: data request accepted
- d_rvalid  out  1  load data valid or store acknowledge
- d_rdata  out  DATA_WIDTH  load data
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  ADDR_WIDTH  memory address, registered
- mem_wdata  out  DATA_WIDTH  memory write data, registered
- mem_ready  in  1  memory accepts request this cycle
- mem_rvalid  in  1  memory response; asserted once per transaction, writes included
- mem_rdata  in  DATA_WIDTH  memory read data

## Operation
- States: S_IDLE, S_ISSUE, S_WAIT. Owner register holds OWN_IF or OWN_D.
- S_IDLE: if any req is high, pick a winner and latch its cmd into the mem_* registers. Set owner and go to S_ISSUE. mem_we is 0 for fetches.
- Arbitration by default is fixed priority, and data wins. The last_owner register updates on every grant.
- S_ISSUE: mem_req is 1 and the mem_* registers hold their values. On mem_ready, the owner's gnt pulses in the same cycle (combinational from mem_ready), mem_req drops on the next edge, and the FSM moves to S_WAIT.
- S_WAIT: on mem_rvalid, the owner's rvalid goes high in the same cycle and its rdata equals mem_rdata.
  - If any req is pending in that same cycle, arbitrate and go straight to S_ISSUE.
  - Otherwise go to S_IDLE.
- The non-owner's rvalid is always 0. rdata outputs are mem_rdata, gated to 0 when that port's rvalid is 0.
- mem_rvalid in S_IDLE or S_ISSUE is ignored.
- Requesters must hold req and payload until gnt. The payload is latched at arbitration, so a later change or a drop of req does not cancel the issued transaction. Its response is still returned.

## Timing
- Reset values: state S_IDLE, owner OWN_IF, last_owner OWN_IF, mem_req/mem_we 0, mem_addr/mem_wdata 0. All gnt/rvalid outputs are 0 and all rdata outputs are 0.
- Reset is asynchronous. Asserting it mid-transaction drops mem_req at once and abandons the outstanding response. A late mem_rvalid after release lands in S_IDLE and is ignored.
- Latency, with the request in cycle 0 and the FSM idle:
  - mem_req is high in cycle 1.
  - gnt comes in the first cycle with mem_ready, at the earliest cycle 1.
  - rvalid comes at the earliest cycle 2.
- Back-to-back throughput: 1 transaction per 2 cycles when mem_ready and mem_rvalid return immediately.
- A fetch waits at most one data transaction under round-robin. Under fixed priority it is unbounded.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration. On a simultaneous request, the port that is not last_owner wins. After reset, data wins first.
- MEM_ARB_RR_EN undefined: fixed priority with data over fetch. last_owner is still maintained but unused.

## Structure
- Package mem_arb_pkg holds:
  - typedef enum state_t {S_IDLE, S_ISSUE, S_WAIT}
  - typedef enum owner_t {OWN_IF, OWN_D}
- Sub-module arb_pick is purely combinational.
  - Inputs: if_req, d_req, last_owner.
  - Outputs: valid, winner.
  - Contains the MEM_ARB_RR_EN selection.

## Test plan
- Reset: hold rst=0 with random inputs -> all outputs 0 and no mem_req. Release -> still idle until a req arrives.
- Single fetch of addr 0x00000004, mem_ready=1, mem_rvalid one cycle after accept with rdata 0x00A00513 -> if_gnt cycle 1, if_rvalid with 0x00A00513 cycle 2, d_rvalid stays 0.
- Simultaneous if_req (0x8) and d_req (store, 0x10, 0xDEADBEEF):
  - Without the macro -> store issues first with mem_we=1, then the fetch issues in the d_rvalid cycle's next state.
  - With MEM_ARB_RR_EN and last_owner=OWN_D -> fetch first.
- mem_ready low for 5 cycles -> mem_req/addr/wdata stable and no gnt. gnt appears in the cycle mem_ready rises.
- rst pulsed low in S_WAIT, then mem_rvalid=1 after release -> mem_req 0 immediately, no rvalid on either port.
- Stray mem_rvalid in S_IDLE with rdata 0x12345678 -> if_rvalid=d_rvalid=0, both rdata 0, state unchanged.
